// File: rtl/frame_writer_pkg.sv
// Shared types and constants for the frame_writer stream-to-memory block.
package frame_writer_pkg;

  typedef enum logic [1:0] {
    FW_IDLE  = 2'd0,
    FW_WRITE = 2'd1,
    FW_DONE  = 2'd2
  } fw_state_t;

  localparam int ROW_W = 16;
  localparam int COL_W = 16;

  function automatic int FW_PIX_TOTAL(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Raster position and word-address counters for frame_writer; the address is
// an incremental counter so no row*width product is ever formed.
module frame_addr_gen
  import frame_writer_pkg::*;
#(
  parameter int          IMG_W     = 256,
  parameter int          IMG_H     = 256,
  parameter int unsigned BASE_ADDR = 32'd0,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [ROW_W-1:0]  row_o,
  output logic [COL_W-1:0]  col_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST  =
    ADDR_W'(BASE_ADDR + 32'(FW_PIX_TOTAL(IMG_W, IMG_H)) - 32'd1);

  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next-position logic: clear wins over advance; column wraps into the next row.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clear_i) begin
      row_d  = {ROW_W{1'b0}};
      col_d  = {COL_W{1'b0}};
      addr_d = ADDR_FIRST;
    end else if (advance_i) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_q == COL_LAST) begin
        col_d = {COL_W{1'b0}};
        if (row_q == ROW_LAST) begin
          row_d = {ROW_W{1'b0}};
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      row_d  = row_q;
      col_d  = col_q;
      addr_d = addr_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= {ROW_W{1'b0}};
      col_q  <= {COL_W{1'b0}};
      addr_q <= {ADDR_W{1'b0}};
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = addr_q;
  assign last_o = (addr_q == ADDR_LAST);

endmodule

// File: rtl/frame_writer.sv
// Raster pixel stream to RAM writer, one pixel per word, row-major from BASE_ADDR.
// Optional FRAME_WRITER_CHECKSUM_EN adds a mod-2^16 pixel sum output.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int          IMG_W     = 256,
  parameter int          IMG_H     = 256,
  parameter int unsigned BASE_ADDR = 32'd0,
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          PIX_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col
`ifdef FRAME_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  fw_state_t         state_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              accept_s;
  logic              clear_s;
  logic              last_s;
  logic [ADDR_W-1:0] addr_s;

  assign pix_ready = (state_q == FW_WRITE);
  assign accept_s  = pix_valid & pix_ready;
  // Entering WRITE from IDLE or DONE; abort in the same cycle suppresses it.
  assign clear_s   = start & ~abort & (state_q != FW_WRITE);

  frame_addr_gen #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear_s),
    .advance_i (accept_s),
    .row_o     (row),
    .col_o     (col),
    .addr_o    (addr_s),
    .last_o    (last_s)
  );

  // Frame FSM with registered write port and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FW_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_we_q <= accept_s;
      if (accept_s) begin
        mem_addr_q  <= addr_s;
        mem_wdata_q <= DATA_W'(pix_data);
      end
      case (state_q)
        FW_IDLE, FW_DONE: begin
          if (abort) begin
            state_q <= FW_IDLE;
          end else if (start) begin
            state_q <= FW_WRITE;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        FW_WRITE: begin
          if (abort) begin
            state_q <= FW_IDLE;
            busy_q  <= 1'b0;
          end else if (accept_s && last_s) begin
            state_q <= FW_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= FW_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Running sum of accepted pixels, restarted with each frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= 16'd0;
    end else if (clear_s) begin
      checksum_q <= 16'd0;
    end else if (accept_s) begin
      checksum_q <= checksum_q + 16'(pix_data);
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer (4x2 frame at 0x100) with randomized stimulus.
module tb_frame_writer;

  localparam int          IMG_W  = 4;
  localparam int          IMG_H  = 2;
  localparam int unsigned BASE   = 32'h100;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          PIX_W  = 8;
  localparam int          TOTAL  = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              pix_valid = 1'b0;
  logic [PIX_W-1:0]  pix_data = '0;
  logic              pix_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic [15:0]       row;
  logic [15:0]       col;
`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  frame_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BASE_ADDR(BASE),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done), .row(row), .col(col)
`ifdef FRAME_WRITER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] mon_a, mon_d;
  int last_csum = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      we_count++;
      if (q_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h required no write", mem_addr);
      end else begin
        mon_a = q_addr.pop_front();
        mon_d = q_data.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(mon_a));
        check("wr_data", 64'(mem_wdata), 64'(mon_d));
      end
    end
  end

  // gap>0: valid every gap-th cycle, gap==0: random valid.
  // pmode 0: pixels 1..N, 1: random, 2: all 0xFF.  abort_after>0 aborts after that many accepts.
  task automatic run_frame(input int gap, input int pmode, input int abort_after, input bit mid_start);
    int acc = 0;
    int cyc = 0;
    int r = 0;
    int c = 0;
    int csum = 0;
    int we_before;
    bit took;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    we_before = we_count;
    check("ready_on_start", 64'(pix_ready), 64'd1);
    check("busy_on_start", 64'(busy), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
    check("row_on_start", 64'(row), 64'd0);
    check("col_on_start", 64'(col), 64'd0);
    while (acc < TOTAL && !(abort_after != 0 && acc == abort_after) && cyc < 400) begin
      pix_valid = (gap > 0) ? ((cyc % gap) == 0) : ($urandom_range(0, 3) != 0);
      case (pmode)
        0: pix_data = 8'(acc + 1);
        2: pix_data = 8'hFF;
        default: pix_data = 8'($urandom);
      endcase
      start = mid_start && (cyc == 5);
      took = pix_valid && pix_ready;
      if (took) begin
        q_addr.push_back(BASE + 32'(r * IMG_W + c));
        q_data.push_back({24'd0, pix_data});
        csum += int'(pix_data);
        acc++;
        c++;
        if (c == IMG_W) begin
          c = 0;
          r = (r + 1) % IMG_H;
        end
      end
      @(posedge clk); #1;
      pix_valid = 1'b0;
      start = 1'b0;
      cyc++;
      if (took) begin
        check("row_pos", 64'(row), 64'(r));
        check("col_pos", 64'(col), 64'(c));
      end
    end
    if (cyc >= 400) begin
      check("frame_timeout", 64'(acc), 64'(TOTAL));
    end
    last_csum = csum;
    if (abort_after == 0) begin
      check("last_we", 64'(mem_we), 64'd1);
      check("done_rise", 64'(done), 64'd1);
      check("busy_fall", 64'(busy), 64'd0);
      check("ready_drop", 64'(pix_ready), 64'd0);
`ifdef FRAME_WRITER_CHECKSUM_EN
      check("checksum", 64'(checksum), 64'(csum & 16'hFFFF));
`endif
    end else begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_ready", 64'(pix_ready), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(q_addr.size()), 64'd0);
    check("we_count", 64'(we_count - we_before), 64'(acc));
  endtask

  initial begin
    #12;
    check("rst_ready", 64'(pix_ready), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_row", 64'(row), 64'd0);
    check("rst_col", 64'(col), 64'd0);
`ifdef FRAME_WRITER_CHECKSUM_EN
    check("rst_checksum", 64'(checksum), 64'd0);
`endif
    #1 reset = 1'b0;

    run_frame(1, 0, 0, 1'b0);

    // done holds while idle-in-DONE and survives an abort back to IDLE
    repeat (4) @(posedge clk);
    #1;
    check("done_hold", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("done_abort_ready", 64'(pix_ready), 64'd0);
    check("done_abort_done", 64'(done), 64'd1);

    run_frame(3, 1, 0, 1'b1);
    run_frame(1, 1, 3, 1'b0);

    // start and abort together from IDLE: abort wins
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_ready", 64'(pix_ready), 64'd0);
    check("start_abort_busy", 64'(busy), 64'd0);

    run_frame(1, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_frame(0, 1, 0, 1'b0);
    end
    run_frame(2, 2, 0, 1'b0);
    check("ff_sum_model", 64'(last_csum), 64'h7F8);
`ifdef FRAME_WRITER_CHECKSUM_EN
    check("checksum_ff", 64'(checksum), 64'h07F8);
`endif

    // asynchronous reset while a write is on the bus
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix_data = 8'(8'h40 + i);
      q_addr.push_back(BASE + 32'(i));
      q_data.push_back(32'(8'h40 + i));
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    check("pre_reset_we", 64'(mem_we), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("areset_we", 64'(mem_we), 64'd0);
    check("areset_addr", 64'(mem_addr), 64'd0);
    check("areset_wdata", 64'(mem_wdata), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_ready", 64'(pix_ready), 64'd0);
    check("areset_row", 64'(row), 64'd0);
    check("areset_col", 64'(col), 64'd0);
    @(posedge clk); #1;
    q_addr.delete();
    q_data.delete();
    reset = 1'b0;

    run_frame(0, 1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
